noc_cord_flit_decoder: RTL and testbench

Receive-side header decoder for the coherence NoC, the counterpart to the cord packer that places the X cord at marker 0 and the Y cord at marker 1. Accepts wormhole flits over a valid/ready link. Splits the destination cord of each header flit into X/Y fields and resolves a dimension-ordered (X-then-Y) output direction against the local cord. Holds that direction for the packet's body flits and presents each flit with its direction through one registered output stage.

---
 rtl/noc_cord_flit_decoder_pkg.sv | 29 ++
 rtl/noc_cord_flit_decoder_if.sv | 25 ++
 rtl/noc_cord_flit_decoder_out_reg.sv | 34 +++
 rtl/noc_cord_flit_decoder.sv | 129 ++++++++++++
 tb/tb_noc_cord_flit_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/noc_cord_flit_decoder_pkg.sv
// Shared direction encoding and cord-marker helper for the NoC header decoder.
package noc_cord_pkg;

  localparam int unsigned dir_width_gp = 5;

  typedef enum logic [2:0] {
    e_dir_p = 3'd0,
    e_dir_w = 3'd1,
    e_dir_e = 3'd2,
    e_dir_n = 3'd3,
    e_dir_s = 3'd4
  } dir_e;

  // Element i is the low bit of dimension i; element dims is the total cord width.
  typedef logic [2:0][31:0] cord_markers_t;

  function automatic cord_markers_t cord_markers(input int unsigned x_w, input int unsigned y_w);
    cord_markers_t m;
    m[0] = 32'd0;
    m[1] = x_w;
    m[2] = x_w + y_w;
    return m;
  endfunction

  function automatic logic [dir_width_gp-1:0] dir_onehot(input dir_e d);
    return dir_width_gp'(1) << d;
  endfunction

endpackage

// File: rtl/noc_cord_flit_decoder_if.sv
// Receive link and registered output link of the flit decoder, seen from the decoder side.
interface noc_cord_flit_decoder_if #(parameter int unsigned flit_width_p = 64);
  import noc_cord_pkg::*;

  logic [flit_width_p-1:0] flit_i;
  logic                    v_i;
  logic                    ready_o;

  logic [flit_width_p-1:0] flit_o;
  logic [dir_width_gp-1:0] dir_o;
  logic                    head_o;
  logic                    v_o;
  logic                    ready_i;

  modport master (
    output flit_i, v_i, ready_i,
    input  ready_o, flit_o, dir_o, head_o, v_o
  );

  modport slave (
    input  flit_i, v_i, ready_i,
    output ready_o, flit_o, dir_o, head_o, v_o
  );

endinterface

// File: rtl/noc_cord_flit_decoder_out_reg.sv
// Single-entry valid/ready pipe register; refills in the same cycle it drains.
module noc_flit_out_reg #(
  parameter int unsigned width_p = 70
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               ready_i
);

  logic [width_p-1:0] data_q;
  logic               v_q;

  assign ready_o = ~v_q | ready_i;
  assign data_o  = data_q;
  assign v_o     = v_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
      v_q    <= 1'b0;
    end else if (v_i & ready_o) begin
      data_q <= data_i;
      v_q    <= 1'b1;
    end else if (ready_i) begin
      v_q    <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_cord_flit_decoder.sv
// Header decoder: X-then-Y direction resolve on header flits, direction held for body flits.
// state   | meaning
// HEAD    | next accepted flit is a header; decode and latch its direction
// BODY    | count_q body flits remain; reuse the latched direction
module noc_cord_flit_decoder
  import noc_cord_pkg::*;
#(
  parameter int unsigned dims_p         = 2,
  parameter int unsigned x_cord_width_p = 10,
  parameter int unsigned y_cord_width_p = 20,
  parameter int unsigned len_width_p    = 4,
  parameter int unsigned flit_width_p   = 64,
  localparam cord_markers_t markers_lp  = cord_markers(x_cord_width_p, y_cord_width_p),
  localparam int unsigned cord_width_lp = markers_lp[dims_p]
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [cord_width_lp-1:0] my_cord_i,
  noc_cord_flit_decoder_if.slave   link
);

  localparam int unsigned x_lo_lp = markers_lp[0];
  localparam int unsigned x_hi_lp = markers_lp[1] - 1;
  localparam int unsigned pay_width_lp = 1 + dir_width_gp + flit_width_p;

  typedef enum logic {
    e_head = 1'b0,
    e_body = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [len_width_p-1:0]  count_q, count_d;
  logic [dir_width_gp-1:0] dir_q, dir_d;

  logic [x_cord_width_p-1:0] dest_x, my_x;
  logic [len_width_p-1:0]    len;
  logic                      y_lt, y_gt;
  dir_e                      dir_dec;
  logic                      head_s;
  logic [dir_width_gp-1:0]   dir_s;
  logic                      ready_lo, v_lo, accept;
  logic [pay_width_lp-1:0]   pay_li, pay_lo;

  assign dest_x = link.flit_i[x_hi_lp:x_lo_lp];
  assign my_x   = my_cord_i[x_hi_lp:x_lo_lp];
  assign len    = link.flit_i[cord_width_lp +: len_width_p];

  if (dims_p > 1) begin : g_y
    localparam int unsigned y_lo_lp = markers_lp[1];
    localparam int unsigned y_hi_lp = markers_lp[2] - 1;
    logic [y_cord_width_p-1:0] dest_y, my_y;
    assign dest_y = link.flit_i[y_hi_lp:y_lo_lp];
    assign my_y   = my_cord_i[y_hi_lp:y_lo_lp];
    assign y_lt   = dest_y < my_y;
    assign y_gt   = dest_y > my_y;
  end else begin : g_no_y
    assign y_lt = 1'b0;
    assign y_gt = 1'b0;
  end

  // X is fully resolved before Y is considered.
  always_comb begin
    dir_dec = e_dir_p;
    if (dest_x < my_x)      dir_dec = e_dir_w;
    else if (dest_x > my_x) dir_dec = e_dir_e;
    else if (y_lt)          dir_dec = e_dir_n;
    else if (y_gt)          dir_dec = e_dir_s;
  end

  assign accept = link.v_i & ready_lo;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_head;
      count_q <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    head_s  = 1'b0;
    dir_s   = dir_q;
    unique case (state_q)
      e_head: begin
        head_s = 1'b1;
        dir_s  = dir_onehot(dir_dec);
        if (accept) begin
          dir_d   = dir_s;
          count_d = len;
          state_d = (len == '0) ? e_head : e_body;
        end
      end
      e_body: begin
        if (accept) begin
          count_d = count_q - len_width_p'(1);
          if (count_q == len_width_p'(1)) state_d = e_head;
        end
      end
      default: state_d = e_head;
    endcase
  end

  assign pay_li = {head_s, dir_s, link.flit_i};

  noc_flit_out_reg #(.width_p(pay_width_lp)) out_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (pay_li),
    .v_i     (link.v_i),
    .ready_o (ready_lo),
    .data_o  (pay_lo),
    .v_o     (v_lo),
    .ready_i (link.ready_i)
  );

  assign link.ready_o = ready_lo;
  assign link.v_o     = v_lo;
  assign link.head_o  = pay_lo[pay_width_lp-1];
  assign link.dir_o   = pay_lo[flit_width_p +: dir_width_gp];
  assign link.flit_o  = pay_lo[flit_width_p-1:0];

endmodule

// File: tb/tb_noc_cord_flit_decoder.sv
// Directed bench for the flit decoder: header decode, body hold, backpressure, reset, boundaries.
module tb_noc_cord_flit_decoder;
  import noc_cord_pkg::*;

  localparam logic [4:0] D_P = 5'b00001;
  localparam logic [4:0] D_W = 5'b00010;
  localparam logic [4:0] D_E = 5'b00100;
  localparam logic [4:0] D_S = 5'b10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] my_cord;
  logic [9:0]  my_cord1;

  always #5 clk = ~clk;

  noc_cord_flit_decoder_if #(.flit_width_p(64)) lnk ();
  noc_cord_flit_decoder_if #(.flit_width_p(64)) lnk1 ();

  noc_cord_flit_decoder dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .my_cord_i (my_cord),
    .link      (lnk)
  );

  noc_cord_flit_decoder #(.dims_p(1)) dut1 (
    .clk_i     (clk),
    .reset_i   (rst),
    .my_cord_i (my_cord1),
    .link      (lnk1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input int x, input int y, input int len);
    logic [63:0] f;
    f = '0;
    f[9:0]   = x[9:0];
    f[29:10] = y[19:0];
    f[33:30] = len[3:0];
    return f;
  endfunction

  function automatic logic [63:0] body(input int i);
    logic [63:0] f;
    f = 64'hB0D1_0000_0000_0000;
    f[15:0] = i[15:0];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] f);
    lnk.flit_i = f;
    lnk.v_i    = 1'b1;
    step();
  endtask

  task automatic chk_out(input string tag, input logic [63:0] f, input logic [4:0] d, input logic h);
    chk({tag, ".v"},    64'(lnk.v_o),    64'd1);
    chk({tag, ".flit"}, lnk.flit_o,      f);
    chk({tag, ".dir"},  64'(lnk.dir_o),  64'(d));
    chk({tag, ".head"}, 64'(lnk.head_o), 64'(h));
  endtask

  logic [63:0] seq [5];
  logic [4:0]  seq_dir [5];
  logic        seq_head [5];
  logic [63:0] f1;

  initial begin
    rst = 1'b1;
    lnk.v_i = 1'b0;  lnk.flit_i = '0;  lnk.ready_i = 1'b1;
    lnk1.v_i = 1'b0; lnk1.flit_i = '0; lnk1.ready_i = 1'b1;
    my_cord  = {20'd7, 10'd5};
    my_cord1 = 10'd5;

    @(negedge clk);
    chk("rst.v_o",    64'(lnk.v_o),    64'd0);
    chk("rst.flit_o", lnk.flit_o,      64'd0);
    chk("rst.dir_o",  64'(lnk.dir_o),  64'd0);
    chk("rst.head_o", 64'(lnk.head_o), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst.ready_o", 64'(lnk.ready_o), 64'd1);
    @(negedge clk);

    // header (3,7) len 0 -> W
    send(hdr(3, 7, 0));
    lnk.v_i = 1'b0;
    chk_out("t1", hdr(3, 7, 0), D_W, 1'b1);

    // header (5,9) len 3, three bodies, then a fresh header
    seq[0] = hdr(5, 9, 3); seq_dir[0] = D_S; seq_head[0] = 1'b1;
    seq[1] = body(1);      seq_dir[1] = D_S; seq_head[1] = 1'b0;
    seq[2] = body(2);      seq_dir[2] = D_S; seq_head[2] = 1'b0;
    seq[3] = body(3);      seq_dir[3] = D_S; seq_head[3] = 1'b0;
    seq[4] = hdr(3, 7, 0); seq_dir[4] = D_W; seq_head[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(seq[i]);
      chk_out($sformatf("t2[%0d]", i), seq[i], seq_dir[i], seq_head[i]);
    end
    lnk.v_i = 1'b0;
    step();

    // local delivery with backpressure on the first body flit
    send(hdr(5, 7, 2));
    chk_out("t3.hdr", hdr(5, 7, 2), D_P, 1'b1);
    send(body(31));
    chk_out("t3.b1", body(31), D_P, 1'b0);
    lnk.ready_i = 1'b0;
    lnk.flit_i  = body(32);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("t3.hold%0d", i), body(31), D_P, 1'b0);
      chk($sformatf("t3.hold%0d.ready_o", i), 64'(lnk.ready_o), 64'd0);
    end
    lnk.ready_i = 1'b1;
    step();
    chk_out("t3.b2", body(32), D_P, 1'b0);
    lnk.v_i = 1'b0;
    step();
    chk("t3.drain.v_o", 64'(lnk.v_o), 64'd0);
    send(hdr(9, 7, 0));
    chk_out("t3.next", hdr(9, 7, 0), D_E, 1'b1);
    lnk.v_i = 1'b0;

    // X-only instance ignores the Y field entirely
    f1 = hdr(5, 0, 0);
    f1[29:10] = 20'hFFFFF;
    lnk1.flit_i = f1;
    lnk1.v_i    = 1'b1;
    step();
    lnk1.v_i = 1'b0;
    chk("t4.v",    64'(lnk1.v_o),    64'd1);
    chk("t4.dir",  64'(lnk1.dir_o),  64'(D_P));
    chk("t4.head", 64'(lnk1.head_o), 64'd1);

    // reset in the middle of a packet drops it
    send(hdr(5, 7, 3));
    send(body(41));
    lnk.v_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5.rst.v_o",  64'(lnk.v_o),    64'd0);
    chk("t5.rst.flit", lnk.flit_o,      64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(hdr(9, 0, 0));
    chk_out("t5.next", hdr(9, 0, 0), D_E, 1'b1);

    // cord extremes
    my_cord = {20'd7, 10'd0};
    send(hdr(1023, 7, 0));
    chk_out("t6.xmax", hdr(1023, 7, 0), D_E, 1'b1);
    my_cord = {20'd7, 10'd1023};
    send(hdr(0, 7, 0));
    chk_out("t6.xmin", hdr(0, 7, 0), D_W, 1'b1);

    // maximum length packet
    my_cord = {20'd7, 10'd5};
    send(hdr(5, 7, 15));
    chk_out("t6.len15.hdr", hdr(5, 7, 15), D_P, 1'b1);
    for (int i = 0; i < 15; i++) begin
      send(body(100 + i));
      chk_out($sformatf("t6.len15.b%0d", i), body(100 + i), D_P, 1'b0);
    end
    send(hdr(3, 7, 0));
    chk_out("t6.len15.next", hdr(3, 7, 0), D_W, 1'b1);
    lnk.v_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
